// File: rtl/rr_lease_arbiter.sv
// rr_lease_arbiter: four-requester round-robin arbiter with registered one-hot grant, settle gap and grant counter; optional lease timeout under LEASE_TIMEOUT_EN
module rr_lease_arbiter #(
    parameter int LEASE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d, win;
    logic busy_q, busy_d;
    logic [7:0] count_q, count_d;
    logic [3:0] req;
    logic rel, drop, expire, timeout_q;
    logic unused;
    assign req = ui_in[3:0];
    assign rel = ui_in[4];
    assign drop = rel | ~req[owner_q];
`ifdef LEASE_TIMEOUT_EN
    logic [7:0] lease_q;
    assign expire = lease_q == 8'(LEASE_CYCLES - 1);
    assign unused = &{1'b0, uio_in, ui_in[7:5]};
    // lease counter restarts at every grant; timeout flags only an expiry that release did not beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lease_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else if (ena) begin
            lease_q   <= (state_q == GRANT) ? lease_q + 8'd1 : 8'd0;
            timeout_q <= (state_q == GRANT) && expire && !drop;
        end
    end
`else
    assign expire = 1'b0;
    assign timeout_q = 1'b0;
    assign unused = &{1'b0, uio_in, ui_in[7:5], 8'(LEASE_CYCLES)};
`endif
    // first requester after the previous owner wins; later iterations have higher priority
    always_comb begin
        win = owner_q;
        for (int i = 4; i >= 1; i--) if (req[owner_q + 2'(i)]) win = owner_q + 2'(i);
    end
    // next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = GRANT;
                grant_d = 4'b0001 << win;
                owner_d = win;
                busy_d  = 1'b1;
                count_d = count_q + 8'd1;
            end
            GRANT: if (drop || expire) begin
                state_d = GAP;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // state register; ena low freezes everything except reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            owner_q <= 2'd3;
            busy_q  <= 1'b0;
            count_q <= 8'd0;
        end else if (ena) begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
    assign uo_out  = {timeout_q, busy_q, owner_q, grant_q};
    assign uio_out = count_q;
    assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_rr_lease_arbiter.sv
// tb_rr_lease_arbiter: vector table, directed corner sequences and random stimulus against a behavioural model
module tb_rr_lease_arbiter;
    localparam int LC = 4;
`ifdef LEASE_TIMEOUT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    int checks = 0, errors = 0;
    int m_phase, m_owner, m_count, m_held;
    bit m_to;
    logic [3:0] rq;

    rr_lease_arbiter #(.LEASE_CYCLES(LC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit e; logic [3:0] q; bit rl; logic [7:0] uo; logic [7:0] cnt;
    } vec_t;
    vec_t tab [14];

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_uo();
        return {m_to, m_phase == 1, 2'(m_owner), (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000};
    endfunction

    // phase 0 = idle, 1 = granted, 2 = settle gap; m_held counts cycles the grant has been visible
    task automatic model(bit r, bit e, logic [3:0] q, bit rl);
        if (!r) begin
            m_phase = 0; m_owner = 3; m_count = 0; m_held = 0; m_to = 0;
        end else if (e) begin
            m_to = 0;
            if (m_phase == 0) begin
                if (q != 0) begin
                    for (int k = 1; k <= 4; k++)
                        if (q[(m_owner + k) % 4]) begin m_owner = (m_owner + k) % 4; break; end
                    m_phase = 1;
                    m_count = (m_count + 1) % 256;
                    m_held = 1;
                end
            end else if (m_phase == 1) begin
                if (rl || !q[m_owner]) m_phase = 2;
                else if (FEAT && m_held == LC) begin m_phase = 2; m_to = 1; end
                else m_held++;
            end else m_phase = 0;
        end
    endtask

    task automatic apply(bit r, bit e, logic [3:0] q, bit rl);
        rst_n = r;
        ena = e;
        ui_in = {3'($urandom), rl, q};
        uio_in = 8'($urandom);
        model(r, e, q, rl);
        @(posedge clk);
        @(negedge clk);
        check("model", {uo_out, uio_out}, {m_uo(), 8'(m_count)});
    endtask

    task automatic one_grant();
        apply(1, 1, 4'hF, 0);
        apply(1, 1, 4'hF, 1);
        apply(1, 1, 4'hF, 0);
    endtask

    initial begin
        tab[0]  = '{0, 1, 4'hF, 0, 8'h30, 8'h00};
        tab[1]  = '{1, 1, 4'hF, 0, 8'h41, 8'h01};
        tab[2]  = '{1, 1, 4'hF, 1, 8'h00, 8'h01};
        tab[3]  = '{1, 1, 4'hF, 0, 8'h00, 8'h01};
        tab[4]  = '{1, 1, 4'hF, 0, 8'h52, 8'h02};
        tab[5]  = '{1, 1, 4'hF, 1, 8'h10, 8'h02};
        tab[6]  = '{1, 1, 4'hF, 0, 8'h10, 8'h02};
        tab[7]  = '{1, 1, 4'hF, 0, 8'h64, 8'h03};
        tab[8]  = '{1, 1, 4'hF, 1, 8'h20, 8'h03};
        tab[9]  = '{1, 1, 4'hF, 0, 8'h20, 8'h03};
        tab[10] = '{1, 1, 4'hF, 0, 8'h78, 8'h04};
        tab[11] = '{1, 1, 4'hF, 1, 8'h30, 8'h04};
        tab[12] = '{1, 1, 4'hF, 0, 8'h30, 8'h04};
        tab[13] = '{1, 1, 4'hF, 0, 8'h41, 8'h05};
        for (int i = 0; i < 14; i++) begin
            apply(tab[i].r, tab[i].e, tab[i].q, tab[i].rl);
            check($sformatf("vec%0d", i), {uo_out, uio_out}, {tab[i].uo, tab[i].cnt});
        end
        check("uio_oe", 16'(uio_oe), 16'h00FF);

`ifndef LEASE_TIMEOUT_EN
        apply(0, 1, 4'b0100, 0);
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 4'b0100, 0);
            check("hold", {uo_out, uio_out}, {8'h64, 8'h01});
        end
        apply(1, 1, 4'b0000, 0);
        check("drop_gap", {uo_out, uio_out}, {8'h20, 8'h01});
        apply(1, 1, 4'b0000, 0);
        check("drop_idle", {uo_out, uio_out}, {8'h20, 8'h01});
`else
        apply(0, 1, 4'b0001, 0);
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 4'b0001, 0);
            check("lease", {uo_out, uio_out}, {8'h41, 8'h01});
        end
        apply(1, 1, 4'b0001, 0);
        check("timeout_gap", {uo_out, uio_out}, {8'h80, 8'h01});
        apply(1, 1, 4'b0001, 0);
        check("timeout_idle", {uo_out, uio_out}, {8'h00, 8'h01});
        apply(1, 1, 4'b0001, 0);
        check("regrant", {uo_out, uio_out}, {8'h41, 8'h02});
        apply(0, 1, 4'b0001, 0);
        for (int i = 0; i < 4; i++) apply(1, 1, 4'b0001, 0);
        apply(1, 1, 4'b0001, 1);
        check("rel_wins", {uo_out, uio_out}, {8'h00, 8'h01});
`endif

        apply(0, 1, 4'b0010, 0);
        apply(1, 1, 4'b0010, 0);
        check("pre_freeze", {uo_out, uio_out}, {8'h52, 8'h01});
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 4'b0000, 0);
            check("freeze", {uo_out, uio_out}, {8'h52, 8'h01});
        end
        apply(1, 1, 4'b0000, 0);
        check("unfreeze", {uo_out, uio_out}, {8'h10, 8'h01});

        apply(0, 1, 4'hF, 0);
        for (int i = 0; i < 126; i++) one_grant();
        apply(1, 1, 4'hF, 0);
        check("count_7f", 16'(uio_out), 16'h007F);
        apply(0, 1, 4'hF, 0);
        check("reset_mid", {uo_out, uio_out}, {8'h30, 8'h00});
        for (int i = 0; i < 256; i++) one_grant();
        check("count_wrap", 16'(uio_out), 16'h0000);

        apply(0, 1, 4'h0, 0);
        rq = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rq = 4'($urandom);
            apply($urandom_range(63) != 0, $urandom_range(7) != 0, rq, $urandom_range(4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
